// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stage enables, bubbles, valids, forwarding, flush, memory-wait and debug-step control for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 32,
    parameter int DBG_SYNC = 2,
    parameter int FWD_EN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic              inst_ready,
    input  logic              mem_ready,
    input  logic              predict_wrong,
    input  logic [REG_AW-1:0] rs_addr_id,
    input  logic [REG_AW-1:0] rt_addr_id,
    input  logic              rs_used_id,
    input  logic              rt_used_id,
    input  logic [REG_AW-1:0] regw_addr_exe,
    input  logic [REG_AW-1:0] regw_addr_mem,
    input  logic [REG_AW-1:0] regw_addr_wb,
    input  logic              wb_wen_exe,
    input  logic              wb_wen_mem,
    input  logic              wb_wen_wb,
    input  logic              mem_ren_exe,
    input  logic              mem_ren_mem,
    input  logic              mem_wen_mem,
    output logic              if_en,
    output logic              id_en,
    output logic              exe_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              id_rst,
    output logic              exe_rst,
    output logic              id_valid,
    output logic              exe_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [1:0]        forwards,
    output logic [1:0]        forwardt,
    output logic              retire,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [DBG_SYNC-1:0] sync_q, sync_d;
    logic                step_prev_q, step_prev_d, step_pending_q, step_pending_d;
    logic                id_valid_q, id_valid_d, exe_valid_q, exe_valid_d;
    logic                mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic                step_edge, step_go, dbg_hold, mem_wait, freeze, flush, hazard;
    logic                rs_e, rs_m, rs_w, rt_e, rt_m, rt_w;

    function automatic logic match(input logic used, input logic [REG_AW-1:0] src,
                                   input logic vld, input logic wen, input logic [REG_AW-1:0] dst);
        return used && src != '0 && vld && wen && dst == src;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic e, input logic m, input logic w, input logic ld);
        return (FWD_EN == 0) ? 2'd0 : (e && !ld) ? 2'd1 : m ? 2'd2 : w ? 2'd3 : 2'd0;
    endfunction

    assign rs_e = match(rs_used_id, rs_addr_id, exe_valid_q, wb_wen_exe, regw_addr_exe);
    assign rs_m = match(rs_used_id, rs_addr_id, mem_valid_q, wb_wen_mem, regw_addr_mem);
    assign rs_w = match(rs_used_id, rs_addr_id, wb_valid_q, wb_wen_wb, regw_addr_wb);
    assign rt_e = match(rt_used_id, rt_addr_id, exe_valid_q, wb_wen_exe, regw_addr_exe);
    assign rt_m = match(rt_used_id, rt_addr_id, mem_valid_q, wb_wen_mem, regw_addr_mem);
    assign rt_w = match(rt_used_id, rt_addr_id, wb_valid_q, wb_wen_wb, regw_addr_wb);

    // A step is available either from an earlier latched edge or from an edge seen right now
    assign step_edge = sync_q[DBG_SYNC-1] & ~step_prev_q;
    assign step_go   = step_pending_q | step_edge;
    assign dbg_hold  = debug_en & ~step_go;
    assign mem_wait  = mem_valid_q & (mem_ren_mem | mem_wen_mem) & ~mem_ready;
    assign freeze    = dbg_hold | mem_wait;
    assign flush     = predict_wrong & exe_valid_q;
    assign hazard    = (FWD_EN != 0) ? (mem_ren_exe & (rs_e | rt_e))
                                     : (rs_e | rs_m | rs_w | rt_e | rt_m | rt_w);

    assign forwards  = fwd_sel(rs_e, rs_m, rs_w, mem_ren_exe);
    assign forwardt  = fwd_sel(rt_e, rt_m, rt_w, mem_ren_exe);
    assign retire    = wb_valid_q & ~freeze;
    assign id_valid  = id_valid_q;
    assign exe_valid = exe_valid_q;
    assign mem_valid = mem_valid_q;
    assign wb_valid  = wb_valid_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // While reset is held the stage controls sit at their free-running values
    always_comb begin
        {if_en, id_en, exe_en, mem_en, wb_en} = '1;
        {id_rst, exe_rst} = '0;
        if (rst) begin
            if (freeze) begin
                {if_en, id_en, exe_en, mem_en, wb_en} = '0;
            end else if (flush) begin
                {id_rst, exe_rst} = '1;
            end else if (hazard) begin
                {if_en, id_en} = '0;
                exe_rst = 1'b1;
            end else if (!inst_ready) begin
                if_en = 1'b0;
                id_rst = 1'b1;
            end
        end
    end

    always_comb begin
        id_valid_d     = id_en  ? ~id_rst : id_valid_q;
        exe_valid_d    = exe_en ? (id_valid_q & ~exe_rst) : exe_valid_q;
        mem_valid_d    = mem_en ? exe_valid_q : mem_valid_q;
        wb_valid_d     = wb_en  ? mem_valid_q : wb_valid_q;
        sync_d         = {sync_q[DBG_SYNC-2:0], debug_step};
        step_prev_d    = sync_q[DBG_SYNC-1];
        step_pending_d = debug_en & step_go & mem_wait;
        stall_cnt_d    = (!dbg_hold && !if_en && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d    = (!freeze && flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q         <= '0;
            step_prev_q    <= 1'b0;
            step_pending_q <= 1'b0;
            id_valid_q     <= 1'b0;
            exe_valid_q    <= 1'b0;
            mem_valid_q    <= 1'b0;
            wb_valid_q     <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            sync_q         <= sync_d;
            step_prev_q    <= step_prev_d;
            step_pending_q <= step_pending_d;
            id_valid_q     <= id_valid_d;
            exe_valid_q    <= exe_valid_d;
            mem_valid_q    <= mem_valid_d;
            wb_valid_q     <= wb_valid_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl with forwarding, non-forwarding and 2-bit-counter instances
module tb_pipe_hazard_ctrl;

    logic       clk, rst, debug_en, debug_step, inst_ready, mem_ready, predict_wrong;
    logic [4:0] rs_addr_id, rt_addr_id, regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic       rs_used_id, rt_used_id, wb_wen_exe, wb_wen_mem, wb_wen_wb;
    logic       mem_ren_exe, mem_ren_mem, mem_wen_mem;

    logic        d1_if_en, d1_id_en, d1_exe_en, d1_mem_en, d1_wb_en, d1_id_rst, d1_exe_rst;
    logic        d1_id_valid, d1_exe_valid, d1_mem_valid, d1_wb_valid, d1_retire;
    logic [1:0]  d1_forwards, d1_forwardt;
    logic [31:0] d1_stall_cnt, d1_flush_cnt;
    logic        d0_if_en, d0_id_en, d0_exe_en, d0_mem_en, d0_wb_en, d0_id_rst, d0_exe_rst;
    logic        d0_id_valid, d0_exe_valid, d0_mem_valid, d0_wb_valid, d0_retire;
    logic [1:0]  d0_forwards, d0_forwardt;
    logic [31:0] d0_stall_cnt, d0_flush_cnt;
    logic        ds_if_en, ds_id_en, ds_exe_en, ds_mem_en, ds_wb_en, ds_id_rst, ds_exe_rst;
    logic        ds_id_valid, ds_exe_valid, ds_mem_valid, ds_wb_valid, ds_retire;
    logic [1:0]  ds_forwards, ds_forwardt;
    logic [1:0]  ds_stall_cnt, ds_flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    pipe_hazard_ctrl #(.FWD_EN(1)) d1 (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step), .inst_ready(inst_ready),
        .mem_ready(mem_ready), .predict_wrong(predict_wrong), .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id), .regw_addr_exe(regw_addr_exe),
        .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb), .wb_wen_exe(wb_wen_exe),
        .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb), .mem_ren_exe(mem_ren_exe), .mem_ren_mem(mem_ren_mem),
        .mem_wen_mem(mem_wen_mem), .if_en(d1_if_en), .id_en(d1_id_en), .exe_en(d1_exe_en), .mem_en(d1_mem_en),
        .wb_en(d1_wb_en), .id_rst(d1_id_rst), .exe_rst(d1_exe_rst), .id_valid(d1_id_valid),
        .exe_valid(d1_exe_valid), .mem_valid(d1_mem_valid), .wb_valid(d1_wb_valid), .forwards(d1_forwards),
        .forwardt(d1_forwardt), .retire(d1_retire), .stall_cnt(d1_stall_cnt), .flush_cnt(d1_flush_cnt)
    );

    pipe_hazard_ctrl #(.FWD_EN(0)) d0 (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step), .inst_ready(inst_ready),
        .mem_ready(mem_ready), .predict_wrong(predict_wrong), .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id), .regw_addr_exe(regw_addr_exe),
        .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb), .wb_wen_exe(wb_wen_exe),
        .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb), .mem_ren_exe(mem_ren_exe), .mem_ren_mem(mem_ren_mem),
        .mem_wen_mem(mem_wen_mem), .if_en(d0_if_en), .id_en(d0_id_en), .exe_en(d0_exe_en), .mem_en(d0_mem_en),
        .wb_en(d0_wb_en), .id_rst(d0_id_rst), .exe_rst(d0_exe_rst), .id_valid(d0_id_valid),
        .exe_valid(d0_exe_valid), .mem_valid(d0_mem_valid), .wb_valid(d0_wb_valid), .forwards(d0_forwards),
        .forwardt(d0_forwardt), .retire(d0_retire), .stall_cnt(d0_stall_cnt), .flush_cnt(d0_flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) ds (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step), .inst_ready(inst_ready),
        .mem_ready(mem_ready), .predict_wrong(predict_wrong), .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id), .regw_addr_exe(regw_addr_exe),
        .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb), .wb_wen_exe(wb_wen_exe),
        .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb), .mem_ren_exe(mem_ren_exe), .mem_ren_mem(mem_ren_mem),
        .mem_wen_mem(mem_wen_mem), .if_en(ds_if_en), .id_en(ds_id_en), .exe_en(ds_exe_en), .mem_en(ds_mem_en),
        .wb_en(ds_wb_en), .id_rst(ds_id_rst), .exe_rst(ds_exe_rst), .id_valid(ds_id_valid),
        .exe_valid(ds_exe_valid), .mem_valid(ds_mem_valid), .wb_valid(ds_wb_valid), .forwards(ds_forwards),
        .forwardt(ds_forwardt), .retire(ds_retire), .stall_cnt(ds_stall_cnt), .flush_cnt(ds_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clr;
        debug_en = 0; debug_step = 0; inst_ready = 1; mem_ready = 1; predict_wrong = 0;
        rs_addr_id = 0; rt_addr_id = 0; rs_used_id = 0; rt_used_id = 0;
        regw_addr_exe = 0; regw_addr_mem = 0; regw_addr_wb = 0;
        wb_wen_exe = 0; wb_wen_mem = 0; wb_wen_wb = 0;
        mem_ren_exe = 0; mem_ren_mem = 0; mem_wen_mem = 0;
    endtask

    task automatic do_reset;
        rst = 0;
        clr();
        #1;
        @(posedge clk);
        #2;
        rst = 1;
    endtask

    initial begin
        rst = 0;
        clr();
        debug_en = 1;
        inst_ready = 0;
        #12;
        chk("rst_if_en", d1_if_en, 1);
        chk("rst_id_en", d1_id_en, 1);
        chk("rst_wb_en", d1_wb_en, 1);
        chk("rst_id_rst", d1_id_rst, 0);
        chk("rst_retire", d1_retire, 0);
        chk("rst_id_valid", d1_id_valid, 0);
        chk("rst_forwards", d1_forwards, 0);
        chk("rst_stall_cnt", d1_stall_cnt, 0);

        // load-use with forwarding, then mispredict, then store wait
        do_reset();
        #1; chk("p1c0_if_en", d1_if_en, 1); chk("p1c0_id_valid", d1_id_valid, 0);
        tick();
        #1; chk("p1c1_id_valid", d1_id_valid, 1); chk("p1c1_exe_valid", d1_exe_valid, 0);
        tick();
        regw_addr_exe = 2; wb_wen_exe = 1; mem_ren_exe = 1;
        rs_addr_id = 2; rt_addr_id = 2; rs_used_id = 1; rt_used_id = 1;
        #1;
        chk("lu_if_en", d1_if_en, 0); chk("lu_id_en", d1_id_en, 0);
        chk("lu_exe_rst", d1_exe_rst, 1); chk("lu_id_rst", d1_id_rst, 0); chk("lu_exe_en", d1_exe_en, 1);
        tick();
        regw_addr_exe = 0; wb_wen_exe = 0; mem_ren_exe = 0;
        regw_addr_mem = 2; wb_wen_mem = 1; mem_ren_mem = 1;
        #1;
        chk("lu_bubble_exe_valid", d1_exe_valid, 0); chk("lu_mem_valid", d1_mem_valid, 1);
        chk("lu_forwards", d1_forwards, 2); chk("lu_forwardt", d1_forwardt, 2);
        chk("lu_resume_if_en", d1_if_en, 1); chk("lu_resume_exe_rst", d1_exe_rst, 0);
        chk("lu_stall_cnt", d1_stall_cnt, 1); chk("lu_ds_stall_cnt", ds_stall_cnt, 1);
        tick();
        regw_addr_exe = 3; wb_wen_exe = 1;
        regw_addr_mem = 0; wb_wen_mem = 0; mem_ren_mem = 0;
        regw_addr_wb = 2; wb_wen_wb = 1;
        rs_addr_id = 3; rt_addr_id = 2;
        #1;
        chk("fw_exe_sel", d1_forwards, 1); chk("fw_wb_sel", d1_forwardt, 3);
        chk("fw_retire", d1_retire, 1); chk("fw_mem_valid", d1_mem_valid, 0);
        tick();
        predict_wrong = 1; inst_ready = 0; rs_used_id = 0; rt_used_id = 0;
        regw_addr_exe = 4; regw_addr_mem = 3; wb_wen_mem = 1; wb_wen_wb = 0;
        #1;
        chk("mp_if_en", d1_if_en, 1); chk("mp_id_en", d1_id_en, 1);
        chk("mp_id_rst", d1_id_rst, 1); chk("mp_exe_rst", d1_exe_rst, 1);
        chk("mp_retire", d1_retire, 0); chk("mp_flush_pre", d1_flush_cnt, 0);
        tick();
        clr();
        #1;
        chk("mp_flush_cnt", d1_flush_cnt, 1); chk("mp_stall_cnt", d1_stall_cnt, 1);
        chk("mp_id_valid", d1_id_valid, 0); chk("mp_exe_valid", d1_exe_valid, 0);
        chk("mp_retire_after", d1_retire, 1);
        tick();
        #1; chk("mp_target_in_id", d1_id_valid, 1);
        tick(); tick(); tick();
        mem_wen_mem = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mw_if_en", d1_if_en, 0); chk("mw_exe_en", d1_exe_en, 0);
            chk("mw_wb_en", d1_wb_en, 0); chk("mw_retire", d1_retire, 0);
            chk("mw_id_valid", d1_id_valid, 1); chk("mw_wb_valid", d1_wb_valid, 1);
            chk("mw_stall_cnt", d1_stall_cnt, 32'(1 + i));
            tick();
        end
        mem_ready = 1;
        #1;
        chk("mw_done_if_en", d1_if_en, 1); chk("mw_done_wb_en", d1_wb_en, 1);
        chk("mw_done_retire", d1_retire, 1); chk("mw_done_stall_cnt", d1_stall_cnt, 5);
        chk("sat_ds_stall_cnt", ds_stall_cnt, 3); chk("sat_ds_flush_cnt", ds_flush_cnt, 1);
        tick();

        // same load-use without forwarding
        do_reset();
        tick(); tick();
        regw_addr_exe = 2; wb_wen_exe = 1; mem_ren_exe = 1;
        rs_addr_id = 2; rt_addr_id = 2; rs_used_id = 1; rt_used_id = 1;
        #1; chk("nf_exe_if_en", d0_if_en, 0); chk("nf_exe_rst", d0_exe_rst, 1); chk("nf_exe_fwd", d0_forwards, 0);
        tick();
        regw_addr_exe = 0; wb_wen_exe = 0; mem_ren_exe = 0;
        regw_addr_mem = 2; wb_wen_mem = 1; mem_ren_mem = 1;
        #1; chk("nf_mem_if_en", d0_if_en, 0); chk("nf_mem_id_en", d0_id_en, 0); chk("nf_mem_fwd", d0_forwardt, 0);
        tick();
        regw_addr_mem = 0; wb_wen_mem = 0; mem_ren_mem = 0;
        regw_addr_wb = 2; wb_wen_wb = 1;
        #1; chk("nf_wb_if_en", d0_if_en, 0); chk("nf_wb_fwd", d0_forwards, 0); chk("nf_wb_stall", d0_stall_cnt, 2);
        tick();
        regw_addr_wb = 0; wb_wen_wb = 0;
        #1; chk("nf_done_if_en", d0_if_en, 1); chk("nf_stall_cnt", d0_stall_cnt, 3);
        tick();

        // register zero never matches
        do_reset();
        tick(); tick();
        regw_addr_exe = 0; wb_wen_exe = 1;
        rs_used_id = 1; rt_used_id = 1;
        #1;
        chk("r0_forwards", d1_forwards, 0); chk("r0_forwardt", d1_forwardt, 0);
        chk("r0_if_en", d1_if_en, 1); chk("r0_nofwd_if_en", d0_if_en, 1);
        mem_ren_exe = 1;
        #1; chk("r0_load_if_en", d1_if_en, 1);
        tick();

        // debug stepping, second step lands in a memory wait
        do_reset();
        tick(); tick(); tick(); tick();
        debug_en = 1; debug_step = 1;
        #1; chk("dbg_hold_if_en", d1_if_en, 0); chk("dbg_hold_retire", d1_retire, 0);
        tick();
        #1; chk("dbg_sync_if_en", d1_if_en, 0);
        tick();
        #1; chk("dbg_step1_if_en", d1_if_en, 1); chk("dbg_step1_retire", d1_retire, 1);
        debug_step = 0;
        tick();
        mem_wen_mem = 1; mem_ready = 0; debug_step = 1;
        #1; chk("dbg_once_if_en", d1_if_en, 0); chk("dbg_held_stall", d1_stall_cnt, 0);
        tick();
        #1; chk("dbg_w1_if_en", d1_if_en, 0);
        tick();
        #1; chk("dbg_w2_if_en", d1_if_en, 0); chk("dbg_w2_retire", d1_retire, 0);
        debug_step = 0;
        tick();
        #1; chk("dbg_w3_if_en", d1_if_en, 0);
        tick();
        mem_ready = 1;
        #1;
        chk("dbg_step2_if_en", d1_if_en, 1); chk("dbg_step2_retire", d1_retire, 1);
        chk("dbg_stall_cnt", d1_stall_cnt, 2);
        tick();
        mem_wen_mem = 0;
        #1; chk("dbg_after_if_en", d1_if_en, 0); chk("dbg_after_id_valid", d1_id_valid, 1);
        rst = 0;
        #1;
        chk("arst_id_valid", d1_id_valid, 0); chk("arst_wb_valid", d1_wb_valid, 0);
        chk("arst_stall_cnt", d1_stall_cnt, 0); chk("arst_if_en", d1_if_en, 1);
        chk("arst_retire", d1_retire, 0);
        tick();
        rst = 1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
